// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port integer register file.
//   rf_state_t : sequencer state (CLEAR after reset, RUN in normal operation)
//   REG_A0     : architectural index of a0 (x10), exported as a continuous view
//   REG_ZERO   : hardwired-zero register index
package regfile_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1
    } rf_state_t;

    localparam int REG_A0   = 10;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_rdport.sv
// Single combinational read port of the register file.
// Ports:
//   busy    in  - clear sequence active; forces the output to zero
//   addr    in  - register address to read
//   mem     in  - flattened register contents (entry 0 already zero)
//   we, wr_addr, wr_data in - current writeback, used only for forwarding
//   data    out - read data
// Build option: REGFILE_BYPASS_EN enables write-first forwarding of the
// writeback in the same cycle; without it the port is read-first.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic                        busy,
    input  logic [AW-1:0]               addr,
    input  logic [2**AW-1:0][DW-1:0]    mem,
    input  logic                        we,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DW-1:0]               wr_data,
    output logic [DW-1:0]               data
);

    logic hit;

`ifdef REGFILE_BYPASS_EN
    // A write to x0 is discarded, so it must not be forwarded either.
    assign hit = we && (wr_addr != AW'(REG_ZERO)) && (addr == wr_addr);
`else
    logic unused_wr;
    assign unused_wr = ^{we, wr_addr, wr_data};
    assign hit       = 1'b0;
`endif

    always_comb begin
        data = '0;
        if (!busy && addr != AW'(REG_ZERO)) begin
            data = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (hit) data = wr_data;
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file (decode stage).
// x0 is hardwired to zero. After reset a sequencer clears x1..x(NREG-1), one
// register per cycle, with busy high; writes are ignored and all read paths
// return zero during that time.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   rd_addr    - NUM_RD packed read addresses, port i at [i*AW +: AW]
//   rd_data    - NUM_RD packed read data, port i at [i*DW +: DW]
//   we, wr_addr, wr_data - writeback write port
//   busy       - clear sequence in progress
//   dbg_addr   - debug read address
//   dbg_data   - registered debug read data (1-cycle latency, never forwarded)
//   a0         - continuous view of x10
// Build option: REGFILE_BYPASS_EN (write-first forwarding on rd_data and a0).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic                 we,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 busy,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data,
    output logic [DW-1:0]        a0
);

    localparam int NREG = 2**AW;

    rf_state_t                  state;
    logic [AW-1:0]              clr_idx;
    logic [DW-1:0]              regs [NREG];
    // Read view with entry 0 tied to zero; regs[0] is never written or read.
    logic [NREG-1:0][DW-1:0]    view;

    // Any state other than RUN (including an illegal encoding) reports busy.
    assign busy = (state != RUN);

    assign view[0] = '0;
    for (genvar g = 1; g < NREG; g++) begin : g_view
        assign view[g] = regs[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_idx  <= AW'(1);
            dbg_data <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[clr_idx] <= '0;
                    clr_idx       <= clr_idx + AW'(1);
                    dbg_data      <= '0;
                    // All-ones index is the last register to clear.
                    if (&clr_idx) state <= RUN;
                end
                RUN: begin
                    if (we && wr_addr != AW'(REG_ZERO)) regs[wr_addr] <= wr_data;
                    dbg_data <= view[dbg_addr];
                end
                default: begin
                    state    <= CLEAR;
                    clr_idx  <= AW'(1);
                    dbg_data <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rdport #(.AW(AW), .DW(DW)) u_rd (
            .busy    (busy),
            .addr    (rd_addr[g*AW +: AW]),
            .mem     (view),
            .we      (we),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[g*DW +: DW])
        );
    end

    regfile_rdport #(.AW(AW), .DW(DW)) u_a0 (
        .busy    (busy),
        .addr    (AW'(REG_A0)),
        .mem     (view),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (a0)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with three read ports.
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic              we = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              busy;
    logic [AW-1:0]     dbg_addr = '0;
    logic [DW-1:0]     dbg_data;
    logic [DW-1:0]     a0;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp #(.AW(AW), .DW(DW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .a0       (a0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [4:0]    wa;
        logic [31:0]   wd;
        logic [4:0]    ra0, ra1, ra2, da;
        logic [31:0]   e0, e1, e2, ea0, edbg;
    } vec_t;

    vec_t vt [9];

    function automatic logic [31:0] pick(input logic [31:0] byp_v, input logic [31:0] nobyp_v);
        return BYP ? byp_v : nobyp_v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] port(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    // Called in the first busy cycle after the reset edge; returns the number
    // of cycles busy was high. A write to x3 is attempted late in the clear.
    task automatic run_clear(output int cnt);
        cnt = 1;
        rd_addr = {5'd5, 5'd10, 5'd5};
        dbg_addr = 5'd5;
        for (int k = 0; k < 100; k++) begin
            if (cnt == 25) begin
                we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
            end else begin
                we = 1'b0;
            end
            #1;
            if (cnt == 5) begin
                chk("clear rd0", port(0), 32'h0);
                chk("clear a0", a0, 32'h0);
                chk("clear dbg", dbg_data, 32'h0);
            end
            tick();
            if (!busy) break;
            cnt++;
        end
        we = 1'b0;
    endtask

    task automatic preload();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wr_addr = AW'(i); wr_data = 32'hDEADBEEF;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i < 32; i++) begin
            rd_addr = {AW'(i), AW'(i), AW'(i)};
            #1;
            for (int p = 0; p < NR; p++)
                chk($sformatf("%s x%0d p%0d", tag, i, p), port(p), 32'h0);
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] e;

        // Initial reset to get into a known state.
        rst = 1'b1;
        tick();
        chk("busy after rst", {31'b0, busy}, 32'd1);
        chk("dbg after rst", dbg_data, 32'h0);
        rst = 1'b0;
        run_clear(cnt);
        chk("first clear len", cnt, 32'd31);

        // Test 1: preload, reset, clear duration and contents.
        preload();
        rd_addr = {5'd31, 5'd10, 5'd5};
        #1;
        chk("preload x5", port(0), 32'hDEADBEEF);
        chk("preload a0", a0, 32'hDEADBEEF);
        rst = 1'b1;
        tick();
        chk("busy rst pulse", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        run_clear(cnt);
        chk("clear len", cnt, 32'd31);
        chk("busy after clear", {31'b0, busy}, 32'd0);
        check_all_zero("clear");
        chk("a0 after clear", a0, 32'h0);

        // Tests 2, 3, 6 as table vectors.
        vt[0] = '{1'b1, 5'd5,  32'h12345678, 5'd0,  5'd0,  5'd0,  5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[1] = '{1'b1, 5'd10, 32'hCAFEF00D, 5'd5,  5'd1,  5'd5,  5'd5,
                  32'h12345678, 32'h0, 32'h12345678, pick(32'hCAFEF00D, 32'h0), 32'h12345678};
        vt[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd10, 5'd5,  5'd10,
                  32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D};
        vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd10, 5'd0,
                  32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
        vt[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd0,  5'd0,
                  32'h0, 32'h12345678, 32'h0, 32'hCAFEF00D, 32'h0};
        vt[5] = '{1'b1, 5'd31, 32'hA,        5'd31, 5'd5,  5'd10, 5'd31,
                  pick(32'hA, 32'h0), 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
        vt[6] = '{1'b1, 5'd31, 32'hB,        5'd31, 5'd31, 5'd0,  5'd31,
                  pick(32'hB, 32'hA), pick(32'hB, 32'hA), 32'h0, 32'hCAFEF00D, 32'hA};
        vt[7] = '{1'b1, 5'd31, 32'hC,        5'd31, 5'd5,  5'd31, 5'd31,
                  pick(32'hC, 32'hB), 32'h12345678, pick(32'hC, 32'hB), 32'hCAFEF00D, 32'hB};
        vt[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 5'd1,  5'd31,
                  32'hC, 32'h0, 32'h0, 32'hCAFEF00D, 32'hC};

        for (int i = 0; i < 9; i++) begin
            we = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_addr = {vt[i].ra2, vt[i].ra1, vt[i].ra0};
            dbg_addr = vt[i].da;
            #1;
            chk($sformatf("v%0d rd0", i), port(0), vt[i].e0);
            chk($sformatf("v%0d rd1", i), port(1), vt[i].e1);
            chk($sformatf("v%0d rd2", i), port(2), vt[i].e2);
            chk($sformatf("v%0d a0", i), a0, vt[i].ea0);
            tick();
            chk($sformatf("v%0d dbg", i), dbg_data, vt[i].edbg);
        end
        we = 1'b0;

        // Back-to-back writes to x31 leave x1..x30 untouched.
        for (int i = 1; i < 31; i++) begin
            rd_addr = {5'd0, AW'(i), 5'd0};
            #1;
            e = (i == 5) ? 32'h12345678 : (i == 10) ? 32'hCAFEF00D : 32'h0;
            chk($sformatf("keep x%0d", i), port(1), e);
        end

        // Test 4: same-cycle write/read of x7.
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
        tick();
        wr_data = 32'h2;
        rd_addr = {5'd0, 5'd0, 5'd7};
        dbg_addr = 5'd7;
        #1;
        chk("byp same cycle", port(0), pick(32'h2, 32'h1));
        tick();
        we = 1'b0;
        #1;
        chk("byp next cycle", port(0), 32'h2);
        chk("dbg pre-write", dbg_data, 32'h1);
        tick();
        chk("dbg post-write", dbg_data, 32'h2);

        // Test 5: reset again at clear cycle 10 restarts the sequence.
        preload();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("busy mid clear", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_clear(cnt);
        chk("restart clear len", cnt, 32'd31);
        check_all_zero("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
